bram_stream_reader: RTL and testbench

- Read-side front end for the dual-port block RAM.
- Accepts a burst command (start address, length) and drives the RAM read port (read address, read enable).
- Captures the RAM's registered read data one cycle after each read.
- Presents the words as a valid/ready stream with a last-word flag.
- Holds off reads that would collide with a same-cycle write to the same address, because the RAM returns undefined data for such reads.

---
 rtl/bram_stream_reader_pkg.sv | 12 +
 rtl/bram_stream_reader_fifo2.sv | 75 +++++++
 rtl/bram_stream_reader.sv | 128 ++++++++++++
 tb/tb_bram_stream_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the block-RAM stream front ends (read side now, write side later).
package bram_stream_reader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of the 2-entry output buffer occupancy count (0..2).
    localparam int unsigned OCC_WIDTH = 2;

endpackage

// File: rtl/bram_stream_reader_fifo2.sv
// Two-entry registered FIFO; entry 0 is always the head, so head outputs come straight from flops.
module fifo2
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic                 head_valid,
    output logic [WIDTH-1:0]     head_data,
    output logic [OCC_WIDTH-1:0] count
);

    logic [WIDTH-1:0]     e0_q, e0_d;
    logic [WIDTH-1:0]     e1_q, e1_d;
    logic [OCC_WIDTH-1:0] count_q, count_d;
    logic                 pop_ok;
    logic                 push_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != OCC_WIDTH'(2)) || pop_ok);

    // Next entry contents and occupancy for every push/pop combination.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == '0) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
                count_d = count_q + OCC_WIDTH'(1);
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - OCC_WIDTH'(1);
            end
            2'b11: begin
                if (count_q == OCC_WIDTH'(1)) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // Occupancy register; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the matching slot is empty.
    always_ff @(posedge clk) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign head_valid = (count_q != '0);
    assign head_data  = e0_q;
    assign count      = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read front end for the dual-port block RAM: issues reads, captures registered
// read data into a 2-entry buffer and presents it as a valid/ready stream.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 11
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
    output logic                  RAM_RE,
    input  logic [DATA_WIDTH-1:0] RAM_DO,
    input  logic                  SNOOP_WE,
    input  logic [ADDR_WIDTH-1:0] SNOOP_WR_ADDR,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_LAST,
    output logic                  BUSY
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  infl_q, infl_d;
    logic                  infl_last_q, infl_last_d;

    logic                  head_valid;
    logic [DATA_WIDTH:0]   head_data;
    logic [OCC_WIDTH-1:0]  count;
    logic                  pop;
    logic                  accept;
    logic                  collide;
    logic                  issue;
    logic                  drained;
    logic [OCC_WIDTH:0]    occ_after;

    assign accept    = CMD_VALID && CMD_READY;
    assign pop       = head_valid && OUT_READY;
    assign occ_after = (OCC_WIDTH+1)'(count) + (OCC_WIDTH+1)'(infl_q) - (OCC_WIDTH+1)'(pop);
    assign collide   = SNOOP_WE && (SNOOP_WR_ADDR == addr_q);
    assign issue     = (state_q == RUN) && (rem_q != '0) &&
                       (occ_after < (OCC_WIDTH+1)'(2)) && !collide;
    // Buffer empty after this cycle's pop, so CMD_READY rises right after the last handshake.
    assign drained   = (rem_q == '0) && !infl_q && (occ_after == '0);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-length commands are accepted but never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (CMD_LEN != '0)) state_d = RUN;
            RUN:  if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and RAM read port.
    always_comb begin
        CMD_READY   = (state_q == IDLE);
        BUSY        = (state_q == RUN);
        RAM_RE      = issue;
        RAM_RD_ADDR = addr_q;
    end

    // Address/length counters and the in-flight read tag.
    always_comb begin
        addr_d      = addr_q;
        rem_d       = rem_q;
        infl_d      = issue;
        infl_last_d = infl_last_q;
        if (accept) begin
            addr_d = CMD_ADDR;
            rem_d  = CMD_LEN;
        end else if (issue) begin
            addr_d      = addr_q + ADDR_WIDTH'(1);
            rem_d       = rem_q - LEN_WIDTH'(1);
            infl_last_d = (rem_q == LEN_WIDTH'(1));
        end
    end

    // Counter registers; reset drops any in-flight read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo2 (
        .clk       (CLK),
        .rst       (RESET),
        .push      (infl_q),
        .push_data ({infl_last_q, RAM_DO}),
        .pop       (pop),
        .head_valid(head_valid),
        .head_data (head_data),
        .count     (count)
    );

    assign OUT_VALID = head_valid;
    assign OUT_DATA  = head_data[DATA_WIDTH-1:0];
    assign OUT_LAST  = head_data[DATA_WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural registered-read RAM.
module tb_bram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 11;

    logic          CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RESET;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_re;
    logic [DW-1:0] ram_do;
    logic          sn_we;
    logic [AW-1:0] sn_wa;
    logic [DW-1:0] sn_wd;
    logic          out_valid, out_ready, out_last, busy;
    logic [DW-1:0] out_data;

    // Small-address instance for the wrap-around case.
    logic          s_cmd_valid, s_cmd_ready;
    logic [3:0]    s_cmd_addr;
    logic [LW-1:0] s_cmd_len;
    logic [3:0]    s_rd_addr;
    logic          s_re;
    logic [DW-1:0] s_do;
    logic          s_valid, s_last, s_busy;
    logic [DW-1:0] s_data;

    int checks = 0;
    int errors = 0;

    bram_stream_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
        .RAM_RD_ADDR(ram_rd_addr), .RAM_RE(ram_re), .RAM_DO(ram_do),
        .SNOOP_WE(sn_we), .SNOOP_WR_ADDR(sn_wa),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_LAST(out_last),
        .BUSY(busy)
    );

    bram_stream_reader #(
        .ADDR_WIDTH(4), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut_small (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(s_cmd_valid), .CMD_READY(s_cmd_ready), .CMD_ADDR(s_cmd_addr), .CMD_LEN(s_cmd_len),
        .RAM_RD_ADDR(s_rd_addr), .RAM_RE(s_re), .RAM_DO(s_do),
        .SNOOP_WE(1'b0), .SNOOP_WR_ADDR(4'd0),
        .OUT_VALID(s_valid), .OUT_READY(1'b1), .OUT_DATA(s_data), .OUT_LAST(s_last),
        .BUSY(s_busy)
    );

    // Main RAM: mem[i] = i*3 unless overwritten; a read colliding with a write returns poison.
    logic [1023:0] wr_flag = '0;
    logic [DW-1:0] wmem [0:1023];
    always @(posedge CLK) begin
        if (ram_re) begin
            if (sn_we && sn_wa == ram_rd_addr)
                ram_do <= 32'hDEAD_BEEF;
            else if (wr_flag[ram_rd_addr])
                ram_do <= wmem[ram_rd_addr];
            else
                ram_do <= 32'(ram_rd_addr) * 32'd3;
        end
        if (sn_we) begin
            wmem[sn_wa]    <= sn_wd;
            wr_flag[sn_wa] <= 1'b1;
        end
    end

    // Small RAM: mem[i] = 0x100 + i.
    always @(posedge CLK) begin
        if (s_re) s_do <= 32'h100 + 32'(s_rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    int            issued, popped, outstanding, popi, nwords;
    logic          exp_re, hold_valid, done;
    logic [DW-1:0] hold_data;
    logic [3:0]    wa;

    initial begin
        RESET = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        sn_we = 1'b0; sn_wa = '0; sn_wd = '0;
        s_cmd_valid = 1'b0; s_cmd_addr = '0; s_cmd_len = '0;
        repeat (3) cyc();
        RESET = 1'b0;
        cyc(); #2;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_ram_re", 64'(ram_re), 64'(0));
        chk("rst_small_cmd_ready", 64'(s_cmd_ready), 64'(1));

        // Basic burst: 4 words from 0x010.
        cyc(); cmd_valid = 1'b1; cmd_addr = 10'h010; cmd_len = 11'd4; out_ready = 1'b1; #2;
        chk("basic_accept_ready", 64'(cmd_ready), 64'(1));
        cyc(); cmd_valid = 1'b0; #2;
        chk("basic_c1_re", 64'(ram_re), 64'(1));
        chk("basic_c1_addr", 64'(ram_rd_addr), 64'(10'h010));
        chk("basic_c1_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("basic_c1_busy", 64'(busy), 64'(1));
        chk("basic_c1_valid", 64'(out_valid), 64'(0));
        cyc(); #2;
        chk("basic_c2_re", 64'(ram_re), 64'(1));
        chk("basic_c2_addr", 64'(ram_rd_addr), 64'(10'h011));
        chk("basic_c2_valid", 64'(out_valid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            cyc(); #2;
            chk("basic_valid", 64'(out_valid), 64'(1));
            chk("basic_data", 64'(out_data), 64'(32'h30 + 32'(3 * k)));
            chk("basic_last", 64'(out_last), 64'(k == 3));
        end
        cyc(); #2;
        chk("basic_done_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("basic_done_valid", 64'(out_valid), 64'(0));
        chk("basic_done_busy", 64'(busy), 64'(0));

        // Wrap-around on the 4-bit instance: 14,15,0,1.
        cyc(); s_cmd_valid = 1'b1; s_cmd_addr = 4'd14; s_cmd_len = 11'd4; #2;
        cyc(); s_cmd_valid = 1'b0; #2;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin cyc(); #2; end
            if (c <= 4) begin
                wa = 4'(14 + c - 1);
                chk("wrap_re", 64'(s_re), 64'(1));
                chk("wrap_rd_addr", 64'(s_rd_addr), 64'(wa));
            end
            if (c >= 3) begin
                wa = 4'(14 + c - 3);
                chk("wrap_valid", 64'(s_valid), 64'(1));
                chk("wrap_data", 64'(s_data), 64'(32'h100 + 32'(wa)));
                chk("wrap_last", 64'(s_last), 64'(c == 6));
            end
        end
        cyc(); #2;
        chk("wrap_done_cmd_ready", 64'(s_cmd_ready), 64'(1));

        // Backpressure: 8 words from 0x020, OUT_READY pattern 1,0,0,1.
        cyc(); cmd_valid = 1'b1; cmd_addr = 10'h020; cmd_len = 11'd8; out_ready = 1'b1; #2;
        cyc(); cmd_valid = 1'b0;
        issued = 0; popped = 0; hold_valid = 1'b0; done = 1'b0; hold_data = '0;
        for (int c = 0; c < 80 && !done; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #2;
            popi = (out_valid && out_ready) ? 1 : 0;
            outstanding = issued - popped;
            exp_re = (issued < 8) && ((outstanding - popi) < 2);
            chk("bp_ram_re", 64'(ram_re), 64'(exp_re));
            if (ram_re) chk("bp_rd_addr", 64'(ram_rd_addr), 64'(10'h020 + 10'(issued)));
            if (hold_valid) begin
                chk("bp_stall_valid", 64'(out_valid), 64'(1));
                chk("bp_stall_data", 64'(out_data), 64'(hold_data));
            end
            hold_valid = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    chk("bp_data", 64'(out_data), 64'(32'h60 + 32'(3 * popped)));
                    chk("bp_last", 64'(out_last), 64'(popped == 7));
                    popped++;
                end else begin
                    hold_valid = 1'b1;
                    hold_data  = out_data;
                end
            end
            if (ram_re) issued++;
            if (popped == 8) done = 1'b1;
            cyc();
        end
        #2;
        chk("bp_word_count", 64'(popped), 64'(8));
        chk("bp_done_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("bp_done_busy", 64'(busy), 64'(0));

        // Collision: write 0xABCD to address 5 in the first RUN cycle.
        out_ready = 1'b1;
        cyc(); cmd_valid = 1'b1; cmd_addr = 10'd5; cmd_len = 11'd1; #2;
        cyc(); cmd_valid = 1'b0; sn_we = 1'b1; sn_wa = 10'd5; sn_wd = 32'h0000_ABCD; #2;
        chk("col_c1_re", 64'(ram_re), 64'(0));
        chk("col_c1_busy", 64'(busy), 64'(1));
        cyc(); sn_we = 1'b0; #2;
        chk("col_c2_re", 64'(ram_re), 64'(1));
        chk("col_c2_addr", 64'(ram_rd_addr), 64'(10'd5));
        cyc(); #2;
        chk("col_c3_valid", 64'(out_valid), 64'(0));
        cyc(); #2;
        chk("col_c4_valid", 64'(out_valid), 64'(1));
        chk("col_c4_data", 64'(out_data), 64'(32'h0000_ABCD));
        chk("col_c4_last", 64'(out_last), 64'(1));
        cyc(); #2;
        chk("col_done_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("col_done_valid", 64'(out_valid), 64'(0));

        // Zero-length command.
        cyc(); cmd_valid = 1'b1; cmd_addr = 10'h030; cmd_len = 11'd0; #2;
        chk("zero_accept_ready", 64'(cmd_ready), 64'(1));
        cyc(); cmd_valid = 1'b0; #2;
        chk("zero_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("zero_busy", 64'(busy), 64'(0));
        for (int c = 0; c < 3; c++) begin
            chk("zero_re", 64'(ram_re), 64'(0));
            chk("zero_valid", 64'(out_valid), 64'(0));
            cyc(); #2;
        end

        // Reset mid-burst after 2 of 6 words, then a 1-word burst.
        cyc(); cmd_valid = 1'b1; cmd_addr = 10'h040; cmd_len = 11'd6; #2;
        cyc(); cmd_valid = 1'b0; #2;
        cyc(); #2;
        cyc(); #2;
        chk("rstmid_w0", 64'(out_data), 64'(32'hC0));
        chk("rstmid_w0_valid", 64'(out_valid), 64'(1));
        cyc(); #2;
        chk("rstmid_w1", 64'(out_data), 64'(32'hC3));
        cyc(); RESET = 1'b1; #2;
        cyc(); RESET = 1'b0; #2;
        chk("rstmid_valid", 64'(out_valid), 64'(0));
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_re", 64'(ram_re), 64'(0));
        chk("rstmid_cmd_ready", 64'(cmd_ready), 64'(1));
        cyc(); cmd_valid = 1'b1; cmd_addr = 10'h050; cmd_len = 11'd1; #2;
        chk("rstmid_no_stale", 64'(out_valid), 64'(0));
        cyc(); cmd_valid = 1'b0;
        nwords = 0;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (out_valid && out_ready) begin
                chk("one_data", 64'(out_data), 64'(32'hF0));
                chk("one_last", 64'(out_last), 64'(1));
                nwords++;
            end
            cyc();
        end
        #2;
        chk("one_word_count", 64'(nwords), 64'(1));
        chk("one_done_cmd_ready", 64'(cmd_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
